dmem_responder: RTL and testbench

//  Data-memory responder: the memory-side end of the core's load/store interface.

---
 rtl/dmem_responder.sv | 174 +++++++++++++++++
 tb/tb_dmem_responder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// dmem_responder : word-RAM responder for RV32I sized loads/stores (valid/ready)
// Revision 1.0
// ============================================================================
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_size_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int          c_IDXW     = $clog2(DEPTH);
  localparam logic [29:0] c_DEPTH    = 30'(DEPTH);
  localparam logic [3:0]  c_CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_EXEC = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [2:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic [31:0] mem_q [DEPTH];

  logic [c_IDXW-1:0] idx;
  logic [1:0]        lane;
  logic              size_ok;
  logic              misaligned;
  logic              out_of_range;
  logic              acc_err;
  logic [3:0]        be;
  logic [31:0]       wlanes;
  logic [31:0]       word;
  logic [31:0]       shifted;
  logic [31:0]       load_val;

  assign idx          = addr_q[c_IDXW+1:2];
  assign lane         = addr_q[1:0];
  // Upper address bits only matter here; the RAM index ignores them.
  assign out_of_range = (addr_q[31:2] >= c_DEPTH);
  assign acc_err      = ~size_ok | misaligned | out_of_range;

  always_comb begin
    size_ok    = 1'b1;
    misaligned = 1'b0;
    case (size_q)
      3'b000, 3'b100: misaligned = 1'b0;
      3'b001, 3'b101: misaligned = lane[0];
      3'b010:         misaligned = |lane;
      default:        size_ok    = 1'b0;
    endcase
  end

  always_comb begin
    be     = 4'b0000;
    wlanes = wdata_q;
    case (size_q[1:0])
      2'b00: begin
        be     = 4'b0001 << lane;
        wlanes = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be     = 4'b0011 << {lane[1], 1'b0};
        wlanes = {2{wdata_q[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign word    = mem_q[idx];
  assign shifted = word >> {lane, 3'b000};

  always_comb begin
    case (size_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'b0, shifted[7:0]};
      3'b101:  load_val = {16'b0, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  // RAM has no reset; state_q is forced to IDLE during reset so no write can fire.
  always_ff @(posedge clk) begin
    if ((state_q == S_EXEC) && !acc_err && we_q) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) mem_q[idx][l*8 +: 8] <= wlanes[l*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      size_q      <= 3'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            we_q    <= req_we_i;
            size_q  <= req_size_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            if (LATENCY > 1) begin
              state_q <= S_WAIT;
              cnt_q   <= c_CNT_LOAD;
            end else begin
              state_q <= S_EXEC;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd1) begin
            state_q <= S_EXEC;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_EXEC: begin
          state_q     <= S_RESP;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= acc_err;
          rsp_rdata_q <= (acc_err || we_q) ? 32'd0 : load_val;
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o = (state_q == S_IDLE) & rst_n;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// tb_dmem_responder : directed + random checks of dmem_responder (LATENCY 2/1/3)
// Revision 1.0
// ============================================================================
module tb_dmem_responder;

  localparam int DEPTH = 256;

  logic        clk;
  logic        rst_n     [3];
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we    [3];
  logic [2:0]  req_size  [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  // Instance 0: LATENCY 2, instance 1: LATENCY 1, instance 2: LATENCY 3
  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(
      .DEPTH  (DEPTH),
      .LATENCY((g == 0) ? 2 : ((g == 1) ? 1 : 3))
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n[g]),
      .req_valid_i(req_valid[g]),
      .req_ready_o(req_ready[g]),
      .req_we_i   (req_we[g]),
      .req_size_i (req_size[g]),
      .req_addr_i (req_addr[g]),
      .req_wdata_i(req_wdata[g]),
      .rsp_valid_o(rsp_valid[g]),
      .rsp_ready_i(rsp_ready[g]),
      .rsp_rdata_o(rsp_rdata[g]),
      .rsp_err_o  (rsp_err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Byte-addressed reference memory per instance
  logic [7:0] mb [3][4*DEPTH];

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 3);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s did not hold", tag);
    end
  endtask

  // Reference: RV32I sized access on a little-endian byte array
  task automatic model(input int k, input logic we, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] er, output logic ee);
    int n;
    bit sgn;
    bit legal;
    longint v;
    legal = 1'b1;
    sgn   = 1'b0;
    n     = 1;
    case (sz)
      3'd0: begin n = 1; sgn = 1'b1; end
      3'd1: begin n = 2; sgn = 1'b1; end
      3'd2: begin n = 4; sgn = 1'b0; end
      3'd4: begin n = 1; sgn = 1'b0; end
      3'd5: begin n = 2; sgn = 1'b0; end
      default: legal = 1'b0;
    endcase
    ee = !legal || ((int'(a[1:0]) % n) != 0) || (longint'(a) >= 4 * DEPTH);
    er = 32'd0;
    if (!ee) begin
      if (we) begin
        for (int i = 0; i < n; i++) mb[k][int'(a) + i] = 8'(wd >> (8 * i));
      end else begin
        v = 0;
        for (int i = 0; i < n; i++) v = v + (longint'(mb[k][int'(a) + i]) << (8 * i));
        if (sgn && v >= (64'sd1 << (8 * n - 1))) v = v - (64'sd1 << (8 * n));
        er = 32'(v);
      end
    end
  endtask

  // One full transaction; hold>0 stalls rsp_ready and offers a new request meanwhile
  task automatic txn(input int k, input logic we, input logic [2:0] sz,
                     input logic [31:0] a, input logic [31:0] wd, input int hold,
                     output logic [31:0] ro, output logic eo);
    logic [31:0] er;
    logic        ee;
    int          c;
    model(k, we, sz, a, wd, er, ee);
    @(negedge clk);
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_size[k]  = sz;
    req_addr[k]  = a;
    req_wdata[k] = wd;
    rsp_ready[k] = 1'b0;
    c = 0;
    while (!req_ready[k] && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("req_ready_wait", 32'(c < 20), 32'd1);
    @(posedge clk);
    @(negedge clk);
    // Garbage on the request bus while busy must be ignored
    req_we[k]    = 1'($urandom);
    req_size[k]  = 3'($urandom);
    req_addr[k]  = $urandom;
    req_wdata[k] = $urandom;
    chk("busy_ready", 32'(req_ready[k]), 32'd0);
    c = 0;
    while (!rsp_valid[k] && c < 40) begin
      @(negedge clk);
      c++;
    end
    chk("latency", 32'(c), 32'(lat_of(k)));
    ro = rsp_rdata[k];
    eo = rsp_err[k];
    chk("rdata", ro, er);
    chk("err", 32'(eo), 32'(ee));
    if (hold == 0) req_valid[k] = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid[k]), 32'd1);
      chk("hold_rdata", rsp_rdata[k], ro);
      chk("hold_ready", 32'(req_ready[k]), 32'd0);
    end
    rsp_ready[k] = 1'b1;
    @(negedge clk);
    rsp_ready[k] = 1'b0;
    chk("post_valid", 32'(rsp_valid[k]), 32'd0);
    chk("post_ready", 32'(req_ready[k]), 32'd1);
    req_valid[k] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r;
    logic        e;
    logic [31:0] a;
    int          sel;

    for (int k = 0; k < 3; k++) begin
      rst_n[k]     = 1'b0;
      req_valid[k] = 1'b0;
      req_we[k]    = 1'b0;
      req_size[k]  = 3'd0;
      req_addr[k]  = 32'd0;
      req_wdata[k] = 32'd0;
      rsp_ready[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_req_ready", 32'(req_ready[k]), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata[k], 32'd0);
      chk("rst_rsp_err", 32'(rsp_err[k]), 32'd0);
      rst_n[k] = 1'b1;
    end
    @(negedge clk);
    chk("idle_ready", 32'(req_ready[0]), 32'd1);

    // Give instance 0 known contents in bytes 0..255
    for (int w = 0; w < 64; w++) txn(0, 1'b1, 3'b010, 32'(4 * w), $urandom, 0, r, e);

    txn(0, 1'b1, 3'b010, 32'h64, 32'h00000019, 0, r, e);
    chk("sw64_rdata", r, 32'd0);
    txn(0, 1'b0, 3'b010, 32'h64, 32'h0, 0, r, e);
    chk("lw64", r, 32'h00000019);

    txn(0, 1'b1, 3'b010, 32'h10, 32'h80FF7F01, 0, r, e);
    txn(0, 1'b0, 3'b000, 32'h10, 32'h0, 0, r, e);
    chk("lb10", r, 32'h00000001);
    txn(0, 1'b0, 3'b000, 32'h13, 32'h0, 0, r, e);
    chk("lb13", r, 32'hFFFFFF80);
    txn(0, 1'b0, 3'b100, 32'h13, 32'h0, 0, r, e);
    chk("lbu13", r, 32'h00000080);
    txn(0, 1'b0, 3'b001, 32'h12, 32'h0, 0, r, e);
    chk("lh12", r, 32'hFFFF80FF);
    txn(0, 1'b0, 3'b101, 32'h12, 32'h0, 0, r, e);
    chk("lhu12", r, 32'h000080FF);

    txn(0, 1'b1, 3'b010, 32'h20, 32'h11223344, 0, r, e);
    txn(0, 1'b1, 3'b000, 32'h21, 32'h000000AA, 0, r, e);
    txn(0, 1'b1, 3'b001, 32'h22, 32'h0000BEEF, 0, r, e);
    txn(0, 1'b0, 3'b010, 32'h20, 32'h0, 0, r, e);
    chk("lw20_merge", r, 32'hBEEFAA44);

    txn(0, 1'b0, 3'b010, 32'h22, 32'h0, 0, r, e);
    chk("lw22_err", 32'(e), 32'd1);
    txn(0, 1'b0, 3'b001, 32'h21, 32'h0, 0, r, e);
    chk("lh21_err", 32'(e), 32'd1);
    txn(0, 1'b0, 3'b011, 32'h20, 32'h0, 0, r, e);
    chk("size3_err", 32'(e), 32'd1);
    txn(0, 1'b0, 3'b010, 32'h400, 32'h0, 0, r, e);
    chk("lw400_err", 32'(e), 32'd1);
    chk("lw400_rdata", r, 32'd0);
    txn(0, 1'b1, 3'b010, 32'h22, 32'hFFFFFFFF, 0, r, e);
    txn(0, 1'b1, 3'b001, 32'h21, 32'hFFFFFFFF, 0, r, e);
    txn(0, 1'b1, 3'b111, 32'h20, 32'hFFFFFFFF, 0, r, e);
    txn(0, 1'b1, 3'b011, 32'h10, 32'hFFFFFFFF, 0, r, e);
    txn(0, 1'b1, 3'b010, 32'h400, 32'hFFFFFFFF, 0, r, e);
    chk("sw400_err", 32'(e), 32'd1);
    txn(0, 1'b0, 3'b010, 32'h20, 32'h0, 0, r, e);
    chk("lw20_unchanged", r, 32'hBEEFAA44);
    txn(0, 1'b0, 3'b010, 32'h10, 32'h0, 0, r, e);
    chk("lw10_unchanged", r, 32'h80FF7F01);
    txn(0, 1'b0, 3'b010, 32'h0, 32'h0, 0, r, e);

    txn(0, 1'b0, 3'b010, 32'h64, 32'h0, 5, r, e);
    chk("hold_lw64", r, 32'h00000019);

    // Randomized mix of sizes, directions and in/out-of-range addresses
    for (int t = 0; t < 150; t++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = 32'h400 + 32'($urandom_range(0, 255));
      else if (sel == 1) a = $urandom | 32'h0000_1000;
      else               a = 32'($urandom_range(0, 255));
      txn(0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
          $urandom_range(0, 2), r, e);
    end

    txn(1, 1'b1, 3'b010, 32'h64, 32'h00000019, 0, r, e);
    txn(1, 1'b0, 3'b010, 32'h64, 32'h0, 0, r, e);
    chk("lat1_lw64", r, 32'h00000019);
    txn(1, 1'b0, 3'b010, 32'h64, 32'h0, 3, r, e);

    // Reset in the middle of a store on the LATENCY=3 instance
    txn(2, 1'b1, 3'b010, 32'h30, 32'hCAFEF00D, 0, r, e);
    @(negedge clk);
    req_valid[2] = 1'b1;
    req_we[2]    = 1'b1;
    req_size[2]  = 3'b010;
    req_addr[2]  = 32'h30;
    req_wdata[2] = 32'h00000005;
    chk("abort_ready", 32'(req_ready[2]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid[2] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n[2] = 1'b0;
    #1;
    chk("abort_req_ready", 32'(req_ready[2]), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid[2]), 32'd0);
    chk("abort_rsp_rdata", rsp_rdata[2], 32'd0);
    chk("abort_rsp_err", 32'(rsp_err[2]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", 32'(rsp_valid[2]), 32'd0);
    end
    txn(2, 1'b0, 3'b010, 32'h30, 32'h0, 0, r, e);
    chk("abort_lw30", r, 32'hCAFEF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
